// File: rtl/console_writer_if.sv
// Simple request/grant bus used by the console writer; the master holds a
// request and its payload until the slave returns a one-cycle grant.
interface naive_bus;
  logic        rd_req;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport master (output rd_req, wr_req, wr_be, wr_addr, wr_data, input wr_gnt);
  modport slave  (input rd_req, wr_req, wr_be, wr_addr, wr_data, output wr_gnt);
endinterface

// File: rtl/console_writer.sv
// Character stream to text-mode cell memory writer with cursor handling.
// Optional macro CONSOLE_ROW_CLEAR_EN: clear the newly entered row on row advance.
module console_writer #(
  parameter logic [31:0] VRAM_BASE = 32'h0000_0000,
  parameter int          COLS      = 98,
  parameter int          ROWS      = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output logic       o_ready,
  output logic [6:0] o_cur_x,
  output logic [5:0] o_cur_y,
  naive_bus.master   bus
);

  localparam logic [11:0] CELLS_M1 = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_M1  = 12'(COLS - 1);
  localparam logic [6:0]  XMAX     = 7'(COLS - 1);
  localparam logic [5:0]  YMAX     = 6'(ROWS - 1);

  typedef enum logic [1:0] {CLR_ALL, IDLE, WRITE, CLR_ROW} state_e;

  state_e      state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  chr_q, chr_d;
  logic        req_q, req_d;

  logic [11:0] idx;
  logic [7:0]  wbyte;
  logic [5:0]  y_next;
  logic        done;

  always_comb begin
    case (state_q)
      CLR_ALL: idx = cnt_q;
      CLR_ROW: idx = 12'(y_q) * 12'(COLS) + cnt_q;
      default: idx = 12'(y_q) * 12'(COLS) + 12'(x_q);
    endcase
  end

  assign wbyte        = (state_q == WRITE) ? chr_q : 8'h00;
  assign bus.rd_req   = 1'b0;
  assign bus.wr_req   = req_q;
  assign bus.wr_addr  = VRAM_BASE + {20'b0, idx};
  assign bus.wr_be    = 4'b0001 << idx[1:0];
  assign bus.wr_data  = {4{wbyte}};

  assign done    = req_q & bus.wr_gnt;
  assign y_next  = (y_q == YMAX) ? 6'd0 : y_q + 6'd1;
  assign o_ready = (state_q == IDLE);
  assign o_cur_x = x_q;
  assign o_cur_y = y_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    req_d   = req_q;
    case (state_q)
      CLR_ALL: begin
        req_d = 1'b1;
        if (done) begin
          if (cnt_q == CELLS_M1) begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      IDLE: begin
        req_d = 1'b0;
        if (i_valid) begin
          if (i_char >= 8'h20 && i_char <= 8'h7E) begin
            chr_d   = i_char;
            state_d = WRITE;
          end else begin
            case (i_char)
              8'h0D: x_d = '0;
              8'h0A: begin
                x_d = '0;
                y_d = y_next;
`ifdef CONSOLE_ROW_CLEAR_EN
                state_d = CLR_ROW;
                cnt_d   = '0;
`endif
              end
              8'h08: begin
                // backspace erases by writing a zero code; chr 0 marks it
                if (x_q != 7'd0) begin
                  x_d     = x_q - 7'd1;
                  chr_d   = 8'h00;
                  state_d = WRITE;
                end
              end
              8'h0C: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        req_d = 1'b1;
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (chr_q != 8'h00) begin
            if (x_q == XMAX) begin
              x_d = '0;
              y_d = y_next;
`ifdef CONSOLE_ROW_CLEAR_EN
              state_d = CLR_ROW;
              req_d   = 1'b1;
              cnt_d   = '0;
`endif
            end else begin
              x_d = x_q + 7'd1;
            end
          end
        end
      end
      CLR_ROW: begin
        req_d = 1'b1;
        if (done) begin
          if (cnt_q == COLS_M1) begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      default: state_d = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_ALL;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      chr_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameter VRAM_BASE, default 32'h0000_0000: byte base address of the character cell memory on the bus.
REQ-002 Parameter COLS, default 98: characters per row.
REQ-003 Parameter ROWS, default 36: rows per screen.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_valid  input  1  character available on i_char.
REQ-007 i_char  input  8  character code.
REQ-008 o_ready  output  1  character accepted when i_valid & o_ready at a rising edge.
REQ-009 o_cur_x  output  7  cursor column, 0..COLS-1.
REQ-010 o_cur_y  output  6  cursor row, 0..ROWS-1.
REQ-011 bus  naive_bus.master  --  write-only master; rd_req tied 0; drives wr_req, wr_be[3:0], wr_addr[31:0], wr_data[31:0]; samples wr_gnt.

Function
REQ-012 Cell index = o_cur_y*COLS + o_cur_x, 12 bits; write address = VRAM_BASE + index; wr_be = 4'b0001 << index[1:0]; wr_data = code replicated into all four bytes.
REQ-013 States: CLR_ALL, IDLE, WRITE, CLR_ROW; o_ready = 1 only in IDLE.
REQ-014 wr_req held high with addr/data/be stable until the cycle wr_gnt = 1; that cycle completes the write; wr_req may remain high for the next cell in back-to-back clears.
REQ-015 Printable 0x20..0x7E: IDLE -> WRITE; wr_req asserted the cycle after acceptance; on grant column +1 and return to IDLE; with same-cycle grant o_ready is low exactly 2 cycles.
REQ-016 Column wrap: a grant at column COLS-1 sets column 0 and advances the row (REQ-019).
REQ-017 0x0D (CR): column = 0, no bus write, o_ready stays high next cycle.
REQ-018 0x0A (LF): column = 0, row advances (REQ-019).
REQ-019 Row advance: row+1, or 0 from ROWS-1; then CLR_ROW writes 8'h00 to all COLS cells of the new row, columns 0..COLS-1 in order, one per grant, then IDLE; cursor column is 0 during and after.
REQ-020 0x08 (BS): column > 0: column-1, then write 8'h00 at the new position (WRITE); column 0: ignored, no write.
REQ-021 0x0C (FF): CLR_ALL writes 8'h00 to cells 0..COLS*ROWS-1 ascending, then cursor (0,0) and IDLE.
REQ-022 All other codes (0x00..0x1F not listed, 0x7F..0xFF): consumed, no write, no cursor change.
REQ-023 i_valid while o_ready = 0 is not consumed; the character is held by the source.
REQ-024 Clear sequences have no upper bound on wr_gnt wait; no character is lost or reordered under any grant pattern.

Reset
REQ-025 While rst = 1: wr_req = 0, o_ready = 0, o_cur_x = 0, o_cur_y = 0, state CLR_ALL, clear counter 0.
REQ-026 After rst falls, the block performs the full-screen clear of REQ-021 before first asserting o_ready.
REQ-027 rst asserted mid-write or mid-clear aborts it immediately; no partial state persists.

Configuration
REQ-028 Macro CONSOLE_ROW_CLEAR_EN: defined -> row advance runs CLR_ROW per REQ-019; undefined -> row advance updates the cursor only, no bus writes, o_ready high again the cycle after acceptance.

Verification
REQ-029 Reset release with wr_gnt = wr_req: exactly 3528 writes of 0x00, addresses VRAM_BASE+0..+3527, then o_ready = 1 and cursor (0,0).
REQ-030 Send 'A','B' at cursor (0,0): writes data 32'h41414141 be 4'b0001 addr +0, then 32'h42424242 be 4'b0010 addr +1; cursor (2,0).
REQ-031 97 printable chars then 'Z' at (97,0): write at +97, cursor (0,1), then (ROW_CLEAR_EN) 98 zero writes at +98..+195.
REQ-032 At (0,35) send LF: cursor (0,0), zero writes at +0..+97; at (5,3) CR: cursor (0,3), no bus activity.
REQ-033 wr_gnt held low 10 cycles during 'Q' write: wr_req, addr, data stable all 10 cycles, o_ready low, single write on grant.
REQ-034 BS at (0,4): no write, cursor unchanged; BS at (3,4): zero write at +394, cursor (2,4); 0x1B: no write, no cursor change.
